// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - stall/flush/freeze sequencer for the 5-stage pipeline
module pipeline_control_unit #(
  parameter int ADDR_W       = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] iIDSrc1,
  input  logic              iIDSrc1Valid,
  input  logic [ADDR_W-1:0] iIDSrc2,
  input  logic              iIDSrc2Valid,
  input  logic              iEXIsLoad,
  input  logic [ADDR_W-1:0] iEXDest,
  input  logic              iBranchTaken,
  input  logic              iMemReq,
  input  logic              iMemReady,
  output logic              oPCEnable,
  output logic              oPCSelBranch,
  output logic              oIFIDEnable,
  output logic              oIFIDFlush,
  output logic              oIDEXEnable,
  output logic              oIDEXFlush,
  output logic              oEXMEMEnable,
  output logic [1:0]        oState,
  output logic [CNT_W-1:0]  oStallCount,
  output logic              oMemTimeout
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_INIT  = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] STALL_INIT  = 4'(STALL_CYCLES - 1);
  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx, cnt_dec;
  logic [7:0] wait_cnt;
  logic       hz, fz;
  logic       pc_en, pc_sel, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en;

  assign hz = iEXIsLoad & ((iIDSrc1Valid & (iIDSrc1 == iEXDest)) |
                           (iIDSrc2Valid & (iIDSrc2 == iEXDest)));
  assign fz = iMemReq & ~iMemReady;
  assign cnt_dec = cnt - 4'd1;

  always_comb begin
    pc_en    = 1'b1;
    pc_sel   = 1'b0;
    ifid_en  = 1'b1;
    ifid_fl  = 1'b0;
    idex_en  = 1'b1;
    idex_fl  = 1'b0;
    exmem_en = 1'b1;
    state_nx = state;
    cnt_nx   = cnt;
    if (fz) begin
      // Freeze outranks everything; EX keeps its instruction so a branch re-presents later.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else begin
      case (state)
        RUN, LSTALL: begin
          if (iBranchTaken) begin
            pc_sel   = 1'b1;
            ifid_fl  = 1'b1;
            idex_fl  = 1'b1;
            cnt_nx   = FLUSH_INIT;
            state_nx = (FLUSH_INIT == 4'd0) ? RUN : FLUSH;
          end else if (state == LSTALL || hz) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_fl = 1'b1;
            if (state == RUN) begin
              cnt_nx   = STALL_INIT;
              state_nx = (STALL_INIT == 4'd0) ? RUN : LSTALL;
            end else begin
              cnt_nx = cnt_dec;
              if (cnt_dec == 4'd0) state_nx = RUN;
            end
          end
        end
        FLUSH: begin
          ifid_fl = 1'b1;
          cnt_nx  = cnt_dec;
          if (cnt_dec == 4'd0) state_nx = RUN;
        end
        default: begin
          state_nx = RUN;
          cnt_nx   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= RUN;
      cnt         <= 4'd0;
      wait_cnt    <= 8'd0;
      oStallCount <= '0;
      oMemTimeout <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (!pc_en && oStallCount != {CNT_W{1'b1}}) oStallCount <= oStallCount + 1'b1;
      if (fz) begin
        if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
        if (({1'b0, wait_cnt} + 9'd1) >= TIMEOUT_LIM) oMemTimeout <= 1'b1;
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

  // Everything is forced low while reset is held, independent of the state register.
  assign oPCEnable    = Reset & pc_en;
  assign oPCSelBranch = Reset & pc_sel;
  assign oIFIDEnable  = Reset & ifid_en;
  assign oIFIDFlush   = Reset & ifid_fl;
  assign oIDEXEnable  = Reset & idex_en;
  assign oIDEXFlush   = Reset & idex_fl;
  assign oEXMEMEnable = Reset & exmem_en;
  assign oState       = state;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb/tb_pipeline_control_unit.sv - randomized bench with a behavioural model for two configurations
module tb_pipeline_control_unit;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic iIDSrc1 = 0, iIDSrc1Valid = 0, iIDSrc2 = 0, iIDSrc2Valid = 0;
  logic iEXIsLoad = 0, iEXDest = 0, iBranchTaken = 0, iMemReq = 0, iMemReady = 0;

  logic [1:0]  pcen, sel, ifen, iffl, idexen, idexfl, exmem, tmo;
  logic [1:0]  st [2];
  logic [15:0] scnt [2];

  int vectors = 0;
  int miscompares = 0;

  int PS [2] = '{1, 4};
  int PF [2] = '{2, 3};
  int PT [2] = '{16, 5};

  // Model: pending bubble / flush cycles after the current one, plus counters.
  int  sl [2], fl [2], sc [2], wt [2];
  bit  to [2];

  pipeline_control_unit #(.ADDR_W(1), .FLUSH_CYCLES(2), .STALL_CYCLES(1), .MEM_TIMEOUT(16), .CNT_W(16)) dut0 (
    .Clock(Clock), .Reset(Reset), .iIDSrc1(iIDSrc1), .iIDSrc1Valid(iIDSrc1Valid),
    .iIDSrc2(iIDSrc2), .iIDSrc2Valid(iIDSrc2Valid), .iEXIsLoad(iEXIsLoad), .iEXDest(iEXDest),
    .iBranchTaken(iBranchTaken), .iMemReq(iMemReq), .iMemReady(iMemReady),
    .oPCEnable(pcen[0]), .oPCSelBranch(sel[0]), .oIFIDEnable(ifen[0]), .oIFIDFlush(iffl[0]),
    .oIDEXEnable(idexen[0]), .oIDEXFlush(idexfl[0]), .oEXMEMEnable(exmem[0]),
    .oState(st[0]), .oStallCount(scnt[0]), .oMemTimeout(tmo[0]));

  pipeline_control_unit #(.ADDR_W(1), .FLUSH_CYCLES(3), .STALL_CYCLES(4), .MEM_TIMEOUT(5), .CNT_W(16)) dut1 (
    .Clock(Clock), .Reset(Reset), .iIDSrc1(iIDSrc1), .iIDSrc1Valid(iIDSrc1Valid),
    .iIDSrc2(iIDSrc2), .iIDSrc2Valid(iIDSrc2Valid), .iEXIsLoad(iEXIsLoad), .iEXDest(iEXDest),
    .iBranchTaken(iBranchTaken), .iMemReq(iMemReq), .iMemReady(iMemReady),
    .oPCEnable(pcen[1]), .oPCSelBranch(sel[1]), .oIFIDEnable(ifen[1]), .oIFIDFlush(iffl[1]),
    .oIDEXEnable(idexen[1]), .oIDEXFlush(idexfl[1]), .oEXMEMEnable(exmem[1]),
    .oState(st[1]), .oStallCount(scnt[1]), .oMemTimeout(tmo[1]));

  always #5 Clock = ~Clock;

  task automatic check(input string name, input int k, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s dut%0d t=%0t got %0h want %0h", name, k, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_of(input int k);
    return {pcen[k], sel[k], ifen[k], iffl[k], idexen[k], idexfl[k], exmem[k]};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      sl[k] = 0; fl[k] = 0; sc[k] = 0; wt[k] = 0; to[k] = 0;
    end
  endtask

  task automatic check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      check("rst_ctrl", k, ctrl_of(k), 0);
      check("rst_state", k, st[k], 0);
      check("rst_scnt", k, scnt[k], 0);
      check("rst_tmo", k, tmo[k], 0);
    end
  endtask

  // Apply one cycle of inputs, compare against the model, then advance the model at the edge.
  task automatic do_cycle(input logic b, ld, d, s1, s1v, s2, s2v, mr, mrdy);
    logic [6:0] exp_c [2];
    int nsl [2], nfl [2];
    bit hz, fz;
    iBranchTaken = b; iEXIsLoad = ld; iEXDest = d; iIDSrc1 = s1; iIDSrc1Valid = s1v;
    iIDSrc2 = s2; iIDSrc2Valid = s2v; iMemReq = mr; iMemReady = mrdy;
    #2;
    hz = ld && ((s1v && s1 == d) || (s2v && s2 == d));
    fz = mr && !mrdy;
    for (int k = 0; k < 2; k++) begin
      nsl[k] = sl[k]; nfl[k] = fl[k];
      if (fz) exp_c[k] = 7'b0000000;
      else if (b && fl[k] == 0) begin
        exp_c[k] = 7'b1111111; nsl[k] = 0; nfl[k] = PF[k] - 1;
      end else if (fl[k] > 0) begin
        exp_c[k] = 7'b1011101; nfl[k] = fl[k] - 1;
      end else if (sl[k] > 0) begin
        exp_c[k] = 7'b0000111; nsl[k] = sl[k] - 1;
      end else if (hz) begin
        exp_c[k] = 7'b0000111; nsl[k] = PS[k] - 1;
      end else exp_c[k] = 7'b1010101;
      check("ctrl", k, ctrl_of(k), exp_c[k]);
      check("state", k, st[k], (fl[k] > 0) ? 2 : (sl[k] > 0) ? 1 : 0);
      check("stall_count", k, scnt[k], sc[k]);
      check("mem_timeout", k, tmo[k], to[k]);
    end
    @(posedge Clock);
    for (int k = 0; k < 2; k++) begin
      sl[k] = nsl[k]; fl[k] = nfl[k];
      if (!exp_c[k][6] && sc[k] < 65535) sc[k]++;
      if (fz) begin
        wt[k]++;
        if (wt[k] >= PT[k]) to[k] = 1;
      end else wt[k] = 0;
    end
    #1;
  endtask

  task automatic idle();
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #1;
    check_reset_outputs();
    model_clear();
    @(posedge Clock);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    model_clear();
    #1;
    check_reset_outputs();
    @(posedge Clock);
    #1;
    Reset = 1'b1;

    // Load-use: EX load to reg 1, ID reads reg 1.
    do_cycle(0, 1, 1, 1, 1, 0, 0, 0, 0);
    check("t1_state", 0, st[0], 0);
    check("t1_scnt", 0, scnt[0], 1);
    check("t1_state_s4", 1, st[1], 1);
    idle(); idle(); idle(); idle();

    // Branch with FLUSH_CYCLES=2: one flush cycle after the branch cycle.
    do_reset();
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_state_c1", 0, st[0], 2);
    idle();
    check("t2_state_c2", 0, st[0], 0);
    idle(); idle();

    // Freeze for 3 cycles in the middle of a flush.
    do_reset();
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) do_cycle(1, 1, 1, 1, 1, 1, 1, 1, 0);
    check("t3_state_held", 1, st[1], 2);
    idle(); idle(); idle();

    // Branch and load-use together: branch wins.
    do_reset();
    do_cycle(1, 1, 0, 0, 1, 0, 1, 0, 0);
    check("t4_state", 0, st[0], 2);
    check("t4_scnt", 0, scnt[0], 0);
    idle(); idle(); idle();

    // Long memory wait: timeout on the 16th frozen cycle, sticky afterwards.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
      if (i == 14) check("t5_tmo_15", 0, tmo[0], 0);
      if (i == 15) check("t5_tmo_16", 0, tmo[0], 1);
    end
    check("t5_scnt", 0, scnt[0], 20);
    idle(); idle();
    check("t5_sticky", 0, tmo[0], 1);

    // Reset in the middle of a 4-cycle load-use stall.
    do_reset();
    do_cycle(0, 1, 0, 0, 0, 0, 1, 0, 0);
    idle();
    check("t6_pre_state", 1, st[1], 1);
    do_reset();
    check("t6_scnt", 1, scnt[1], 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else do_cycle($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4, 1'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 9) < 3, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
